// File: rtl/vga_pixel_gen.sv
// ============================================================================
// Module      : vga_pixel_gen
// Description : Two-stage pixel colour pipeline: white border, bouncing
//               palette box, dark-green background, delay-matched syncs.
//               Optional 32-pixel grid overlay when VGA_PIXEL_GEN_GRID_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2,
    parameter int BORDER   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [9:0] hcnt,
    input  logic [9:0] vcnt,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_b_in,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       blank_b_out,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam logic [10:0] c_h_active  = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active  = 11'(V_ACTIVE);
    localparam logic [10:0] c_border    = 11'(BORDER);
    localparam logic [10:0] c_h_bord_hi = 11'(H_ACTIVE - BORDER);
    localparam logic [10:0] c_v_bord_hi = 11'(V_ACTIVE - BORDER);
    localparam logic [10:0] c_box_size  = 11'(BOX_SIZE);
    localparam logic [10:0] c_step11    = 11'(STEP);
    localparam logic [9:0]  c_step10    = 10'(STEP);
    localparam logic [10:0] c_x_max11   = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] c_y_max11   = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  c_x_max10   = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  c_y_max10   = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  c_x_init    = 10'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]  c_y_init    = 10'((V_ACTIVE - BOX_SIZE) / 2);

    logic [9:0]  r_box_x, r_box_y;
    logic        r_dx, r_dy;
    logic [1:0]  r_ci;

    logic        r_in_border, r_in_box, r_in_grid;
    logic        r_blank_1, r_hsync_1, r_vsync_1;

    logic [10:0] w_x, w_y, w_bx, w_by;
    logic        w_in_border, w_in_box, w_in_grid, w_tick;

    assign w_x  = {1'b0, hcnt};
    assign w_y  = {1'b0, vcnt};
    assign w_bx = {1'b0, r_box_x};
    assign w_by = {1'b0, r_box_y};

    assign w_in_border = (w_x < c_border) || (w_x >= c_h_bord_hi) ||
                         (w_y < c_border) || (w_y >= c_v_bord_hi);
    assign w_in_box    = (w_x >= w_bx) && (w_x < w_bx + c_box_size) &&
                         (w_y >= w_by) && (w_y < w_by + c_box_size);

`ifdef VGA_PIXEL_GEN_GRID_EN
    assign w_in_grid = (hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0);
`else
    assign w_in_grid = 1'b0;
`endif

    // Start of vertical blank: box moves only here, so a frame never tears.
    assign w_tick = (hcnt == 10'd0) && (w_y == c_v_active);

    logic [10:0] w_x_sum, w_y_sum;
    logic [9:0]  w_nx, w_ny;
    logic        w_flip_x, w_flip_y;

    always_comb begin
        w_x_sum  = w_bx + c_step11;
        w_y_sum  = w_by + c_step11;
        w_nx     = r_box_x;
        w_ny     = r_box_y;
        w_flip_x = 1'b0;
        w_flip_y = 1'b0;

        if (r_dx) begin
            if (w_x_sum >= c_x_max11) begin
                w_nx     = c_x_max10;
                w_flip_x = 1'b1;
            end else begin
                w_nx = w_x_sum[9:0];
            end
        end else if (r_box_x <= c_step10) begin
            w_nx     = 10'd0;
            w_flip_x = 1'b1;
        end else begin
            w_nx = r_box_x - c_step10;
        end

        if (r_dy) begin
            if (w_y_sum >= c_y_max11) begin
                w_ny     = c_y_max10;
                w_flip_y = 1'b1;
            end else begin
                w_ny = w_y_sum[9:0];
            end
        end else if (r_box_y <= c_step10) begin
            w_ny     = 10'd0;
            w_flip_y = 1'b1;
        end else begin
            w_ny = r_box_y - c_step10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_box_x <= c_x_init;
            r_box_y <= c_y_init;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
            r_ci    <= 2'd0;
        end else if (w_tick && run) begin
            r_box_x <= w_nx;
            r_box_y <= w_ny;
            r_dx    <= r_dx ^ w_flip_x;
            r_dy    <= r_dy ^ w_flip_y;
            // A corner hit flips both axes but advances the colour only once.
            if (w_flip_x || w_flip_y) begin
                r_ci <= r_ci + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_border <= 1'b0;
            r_in_box    <= 1'b0;
            r_in_grid   <= 1'b0;
            r_blank_1   <= 1'b0;
            r_hsync_1   <= 1'b1;
            r_vsync_1   <= 1'b1;
        end else begin
            r_in_border <= w_in_border;
            r_in_box    <= w_in_box;
            r_in_grid   <= w_in_grid;
            r_blank_1   <= blank_b_in;
            r_hsync_1   <= hsync_in;
            r_vsync_1   <= vsync_in;
        end
    end

    logic [23:0] w_palette;

    always_comb begin
        w_palette = 24'hFF0000;
        case (r_ci)
            2'd0:    w_palette = 24'hFF0000;
            2'd1:    w_palette = 24'h00FF00;
            2'd2:    w_palette = 24'h0000FF;
            default: w_palette = 24'hFFFF00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {red, green, blue} <= 24'h000000;
            blank_b_out        <= 1'b0;
            hsync_out          <= 1'b1;
            vsync_out          <= 1'b1;
        end else begin
            blank_b_out <= r_blank_1;
            hsync_out   <= r_hsync_1;
            vsync_out   <= r_vsync_1;
            if (!r_blank_1) begin
                {red, green, blue} <= 24'h000000;
            end else if (r_in_border) begin
                {red, green, blue} <= 24'hFFFFFF;
            end else if (r_in_box) begin
                {red, green, blue} <= w_palette;
            end else if (r_in_grid) begin
                {red, green, blue} <= 24'h404040;
            end else begin
                {red, green, blue} <= 24'h000F00;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_gen.sv
// ============================================================================
// Module      : tb_vga_pixel_gen
// Description : Directed self-checking bench for vga_pixel_gen (grid expectation
//               follows VGA_PIXEL_GEN_GRID_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [9:0] hcnt = 10'd1;
    logic [9:0] vcnt = 10'd0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       blank_b_in = 1'b0;
    logic       hsync_out, vsync_out, blank_b_out;
    logic [7:0] red, green, blue;

    int checks = 0;
    int errors = 0;

    vga_pixel_gen dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_b_in  (blank_b_in),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blank_b_out (blank_b_out),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Hold one visible pixel for two clocks, then compare the colour it produced.
    task automatic pix(input int x, input int y, input logic [23:0] exp);
        @(negedge clk);
        hcnt = 10'(x); vcnt = 10'(y);
        blank_b_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("rgb(%0d,%0d)", x, y), {8'h0, red, green, blue}, {8'h0, exp});
    endtask

    task automatic tick();
        @(negedge clk);
        hcnt = 10'd0; vcnt = 10'd480; blank_b_in = 1'b0;
        @(negedge clk);
        hcnt = 10'd1;
    endtask

    logic [9:0]  vx  [0:3] = '{10'd304, 10'd0, 10'd100, 10'd700};
    logic [9:0]  vy  [0:3] = '{10'd224, 10'd0, 10'd100, 10'd10};
    logic        vbl [0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        vhs [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        vvs [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [23:0] vexp[0:3] = '{24'hFF0000, 24'hFFFFFF, 24'h000F00, 24'h000000};

    initial begin
        // Reset state
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
        chk("rst_blank", {31'h0, blank_b_out}, 32'h0);
        chk("rst_hsync", {31'h0, hsync_out}, 32'h1);
        chk("rst_vsync", {31'h0, vsync_out}, 32'h1);
        reset = 1'b0;

        // Pipelined static vectors, two-cycle latency on colour and syncs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("vec%0d_rgb", i - 2), {8'h0, red, green, blue}, {8'h0, vexp[i-2]});
                chk($sformatf("vec%0d_hs", i - 2), {31'h0, hsync_out}, {31'h0, vhs[i-2]});
                chk($sformatf("vec%0d_vs", i - 2), {31'h0, vsync_out}, {31'h0, vvs[i-2]});
                chk($sformatf("vec%0d_bl", i - 2), {31'h0, blank_b_out}, {31'h0, vbl[i-2]});
            end
            if (i < 4) begin
                hcnt = vx[i]; vcnt = vy[i]; blank_b_in = vbl[i];
                hsync_in = vhs[i]; vsync_in = vvs[i];
            end else begin
                hcnt = 10'd1; vcnt = 10'd0; blank_b_in = 1'b0;
                hsync_in = 1'b1; vsync_in = 1'b1;
            end
        end

        // One tick with run=1 moves box to (306,226)
        run = 1'b1;
        tick();
        pix(306, 226, 24'hFF0000);
        pix(305, 226, 24'h000F00);
        pix(337, 257, 24'hFF0000);
        pix(338, 257, 24'h000F00);
        pix(337, 258, 24'h000F00);

        // Tick with run=0 leaves the box alone
        run = 1'b0;
        tick();
        pix(306, 226, 24'hFF0000);
        pix(305, 226, 24'h000F00);

        // Reset asserted mid-line acts immediately
        @(negedge clk);
        hcnt = 10'd0; vcnt = 10'd0; blank_b_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_rgb", {8'h0, red, green, blue}, 32'h00FFFFFF);
        chk("pre_rst_hs", {31'h0, hsync_out}, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rgb", {8'h0, red, green, blue}, 32'h0);
        chk("mid_rst_blank", {31'h0, blank_b_out}, 32'h0);
        chk("mid_rst_hs", {31'h0, hsync_out}, 32'h1);
        chk("mid_rst_vs", {31'h0, vsync_out}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        pix(304, 224, 24'hFF0000);
        pix(303, 224, 24'h000F00);
        pix(335, 255, 24'hFF0000);

        // Coarse frame sweep: box fixed through active lines, one tick per frame
        run = 1'b1;
        for (int v = 0; v < 480; v++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                vcnt = 10'(v);
                hcnt = (k == 0) ? 10'd0 : (k == 1) ? 10'd1 : (k == 2) ? 10'd400 : 10'd799;
                blank_b_in = (k < 3);
            end
        end
        pix(304, 224, 24'hFF0000);
        pix(303, 224, 24'h000F00);
        for (int v = 480; v < 525; v++) begin
            if (v == 480) begin
                for (int h = 0; h < 800; h++) begin
                    @(negedge clk);
                    vcnt = 10'(v); hcnt = 10'(h); blank_b_in = 1'b0;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    vcnt = 10'(v);
                    hcnt = (k == 0) ? 10'd0 : (k == 1) ? 10'd1 : (k == 2) ? 10'd400 : 10'd799;
                    blank_b_in = 1'b0;
                end
            end
        end
        pix(306, 226, 24'hFF0000);
        pix(305, 226, 24'h000F00);

        // 112 ticks total since reset: box_y bounces at 448, colour -> green
        for (int t = 0; t < 111; t++) tick();
        pix(528, 448, 24'h00FF00);
        pix(527, 448, 24'h000F00);
        pix(528, 447, 24'h000F00);
        pix(559, 475, 24'h00FF00);
        tick();
        pix(530, 446, 24'h00FF00);
        pix(530, 445, 24'h000F00);
        pix(529, 446, 24'h000F00);

        // Grid pixel
`ifdef VGA_PIXEL_GEN_GRID_EN
        pix(64, 100, 24'h404040);
`else
        pix(64, 100, 24'h000F00);
`endif
        pix(639, 200, 24'hFFFFFF);
        pix(200, 476, 24'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
